// File: rtl/res_mem_writer_pkg.sv
// Shared width constants and defaults for the result-RAM writer.
// Falls back to the project-wide sizes when _parameter.v is absent.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef TOTAL_ADDR
`define TOTAL_ADDR 256
`endif
`ifndef RES_PARK_ADDR
`define RES_PARK_ADDR (`TOTAL_ADDR - 1)
`endif

package res_mem_writer_pkg;

    localparam int RES_DATA_WIDTH = `DATA_WIDTH;
    localparam int RES_ADDR_WIDTH = `ADDR_WIDTH;
    localparam int RES_NUM_WORDS  = `TOTAL_ADDR - 1;
    localparam int RES_PARK_ADDR  = `RES_PARK_ADDR;

endpackage

// File: rtl/res_mem_writer.sv
// Write-side sequencer for res_mem: frames NUM_WORDS result words,
// parks the address on a scratch slot whenever nothing is written.
module res_mem_writer
    import res_mem_writer_pkg::*;
#(
    parameter int DATA_WIDTH = RES_DATA_WIDTH,
    parameter int ADDR_WIDTH = RES_ADDR_WIDTH,
    parameter int NUM_WORDS  = RES_NUM_WORDS,
    parameter int PARK_ADDR  = RES_PARK_ADDR
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err_len
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] PARK     = ADDR_WIDTH'(PARK_ADDR);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic                  accept;
    logic                  at_last;

    // Handshake and status decode from the state register only
    always_comb begin
        in_ready = (state == RUN);
        busy     = (state != IDLE);
        done     = (state == DONE);
        accept   = (state == RUN) && in_valid;
        at_last  = (wr_ptr == LAST_PTR);
    end

    // FSM, write pointer, RAM-facing registers and sticky length error
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            mem_address <= PARK;
            mem_data    <= '0;
            err_len     <= 1'b0;
        end else begin
            mem_address <= PARK;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        wr_ptr  <= '0;
                        err_len <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        mem_address <= wr_ptr;
                        mem_data    <= in_data;
                        wr_ptr      <= wr_ptr + 1'b1;
                        // in_last must coincide exactly with the final count
                        if (in_last != at_last) begin
                            err_len <= 1'b1;
                        end
                        if (at_last) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_res_mem_writer.sv
// Directed bench for res_mem_writer with a behavioural res_mem
// that writes on every clock, like the real always-enabled RAM.
module tb_res_mem_writer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [7:0]  mem_address;
    logic [31:0] mem_data;
    logic        busy;
    logic        done;
    logic        err_len;

    logic [31:0] ram [256];
    bit          written [256];

    int nvec = 0;
    int nerr = 0;

    res_mem_writer #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(8),
        .NUM_WORDS (4),
        .PARK_ADDR (255)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .mem_address(mem_address),
        .mem_data   (mem_data),
        .busy       (busy),
        .done       (done),
        .err_len    (err_len)
    );

    always #5 clock = ~clock;

    // Write-enable tied high: every edge stores the presented word
    always @(posedge clock) begin
        ram[mem_address]     <= mem_data;
        written[mem_address] <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic frame(input logic [31:0] base, input logic [7:0] vpat,
                         input int ncyc, input int last_at,
                         input int start_at, input logic exp_err);
        int w;
        int nd;
        w  = 0;
        nd = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ready_after_start", 32'(in_ready), 32'd1);
        check("err_cleared_by_start", 32'(err_len), 32'd0);
        for (int c = 0; c < ncyc; c++) begin
            in_valid = vpat[c];
            in_data  = base + 32'(w);
            in_last  = vpat[c] && (w == last_at);
            start    = (c == start_at);
            tick();
            start = 1'b0;
            nd += int'(done);
            if (vpat[c]) begin
                check("acc_addr", 32'(mem_address), 32'(w));
                check("acc_data", mem_data, base + 32'(w));
                w++;
            end else begin
                check("stall_park", 32'(mem_address), 32'd255);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd1);
        check("done_not_ready", 32'(in_ready), 32'd0);
        check("err_len", 32'(err_len), 32'(exp_err));
        tick();
        nd += int'(done);
        check("done_drop", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_park", 32'(mem_address), 32'd255);
        check("err_len_hold", 32'(err_len), 32'(exp_err));
        check("done_count", 32'(nd), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("ram_word", ram[i], base + 32'(i));
        end
    endtask

    initial begin
        int dirty;
        reset    = 1'b1;
        start    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (3) tick();
        check("rst_addr", 32'(mem_address), 32'd255);
        check("rst_data", mem_data, 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err_len), 32'd0);
        reset = 1'b0;
        tick();

        // clean frame
        frame(32'hA0, 8'b0000_1111, 4, 3, -1, 1'b0);
        tick();
        // stalled frame: valid 1,0,0,1,1,0,1
        frame(32'hB0, 8'b0101_1001, 7, 3, -1, 1'b0);
        dirty = 0;
        for (int i = 4; i < 255; i++) begin
            dirty += int'(written[i]);
        end
        check("ram_untouched", 32'(dirty), 32'd0);
        // early in_last, then a clean frame clears the error
        frame(32'hC0, 8'b0000_1111, 4, 1, -1, 1'b1);
        frame(32'hD0, 8'b0000_1111, 4, 3, -1, 1'b0);
        // start mid-frame is ignored
        frame(32'hE0, 8'b0000_1111, 4, 3, 2, 1'b0);

        // reset after two accepted words
        start = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'hF0;
        tick();
        in_data = 32'hF1;
        tick();
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_addr", 32'(mem_address), 32'd255);
        check("mid_rst_ram0", ram[0], 32'hF0);
        check("mid_rst_ram1", ram[1], 32'hF1);
        check("mid_rst_ram2", ram[2], 32'hE2);
        tick();
        check("mid_rst_idle_done", 32'(done), 32'd0);
        frame(32'h50, 8'b0000_1111, 4, 3, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/res_mem_writer.md
# res_mem_writer

Write-side sequencer for the result RAM (`res_mem`). It accepts result words from the modular-exponentiation core over a valid/ready stream and drives the RAM's address and data lines. It parks the address on a reserved scratch location whenever no result word is being written, because `res_mem` has its write-enable tied high and writes on every clock. It frames one complete result (NUM_WORDS words), reports completion, and flags framing errors.

## Interface
Parameters:
- DATA_WIDTH, default `DATA_WIDTH: result word width; must equal the `res_mem` data width.
- ADDR_WIDTH, default `ADDR_WIDTH: RAM address width.
- NUM_WORDS, default `TOTAL_ADDR - 1: words per result frame; legal range 1..2^ADDR_WIDTH-1.
- PARK_ADDR, default `TOTAL_ADDR - 1: scratch address written during idle cycles; must lie outside 0..NUM_WORDS-1.

Ports:
- clock, in, 1: single clock for the block.
- reset, in, 1: synchronous, active-high reset.
- start, in, 1: one-cycle pulse that opens a new frame; honoured only in IDLE.
- in_data, in, DATA_WIDTH: result word from the core.
- in_valid, in, 1: in_data is valid.
- in_last, in, 1: core marks the final word of its frame.
- in_ready, out, 1: block accepts a word this cycle.
- mem_address, out, ADDR_WIDTH: to `res_mem` address.
- mem_data, out, DATA_WIDTH: to `res_mem` data.
- busy, out, 1: frame in progress.
- done, out, 1: one-cycle pulse when a frame completes.
- err_len, out, 1: sticky framing error.

## Operation
- FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - in_ready=0, busy=0.
  - start=1 → RUN, with wr_ptr←0 and err_len←0.
- RUN:
  - in_ready=1, busy=1.
  - A word is accepted when in_valid=1.
  - On acceptance: mem_address←wr_ptr, mem_data←in_data, wr_ptr←wr_ptr+1.
- Length check, evaluated on each accepted word:
  - If in_last=1 and wr_ptr≠NUM_WORDS-1, err_len←1.
  - If wr_ptr=NUM_WORDS-1 and in_last=0, err_len←1.
  - Either way, the frame always ends by count, never on in_last.
- Acceptance of word NUM_WORDS-1 → DONE.
- DONE:
  - in_ready=0, busy=1, done=1 for exactly this one cycle.
  - Next cycle → IDLE.
- Address parking: any cycle without an acceptance, including IDLE, DONE and RUN cycles with in_valid=0, registers mem_address←PARK_ADDR. mem_data holds its last value.
- start while in RUN or DONE is ignored and does not reset wr_ptr.
- wr_ptr is ADDR_WIDTH bits wide and never wraps, because NUM_WORDS ≤ 2^ADDR_WIDTH-1.
- err_len holds until the next honoured start or reset.

## Timing
- Reset values:
  - state=IDLE, wr_ptr=0.
  - mem_address=PARK_ADDR, mem_data=0.
  - in_ready=0, busy=0, done=0, err_len=0.
- in_ready and busy decode from the state register only, with no combinational path from inputs.
- Latency:
  - A word accepted at edge N appears on mem_address/mem_data after edge N.
  - `res_mem` writes it at edge N+1.
- done asserts in the cycle after the last acceptance, together with the final word's address/data presentation. The final word is therefore written at the edge that ends the DONE cycle.
- Start-to-accept: start sampled at edge N; in_ready=1 from edge N onward; the first acceptance is possible at edge N+1.
- Back-to-back frames: a start in the cycle after DONE (IDLE) is honoured. Minimum frame period is NUM_WORDS+2 cycles.
- Reset mid-frame:
  - Immediate return to reset values and the address parks next cycle.
  - Words already written stay in the RAM; no done is issued.
- reset has priority over start.

## Structure
- Width constants come from the shared `_parameter.v` (`DATA_WIDTH, `ADDR_WIDTH, `TOTAL_ADDR).
- Add `RES_PARK_ADDR to `_parameter.v`; top-level and bench use it.
- FSM state encodings are local parameters: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- No sub-module. The block is a single FSM plus pointer and output registers.
- `res_mem` is instantiated by the parent alongside this block, not inside it.

## Test plan
Bench overrides: NUM_WORDS=4, ADDR_WIDTH=8, PARK_ADDR=255, DATA_WIDTH=32. A behavioural RAM model checks contents.

- **Reset:** hold reset 3 cycles → mem_address=255, mem_data=0, in_ready=0, busy=0, done=0, err_len=0.
- **Clean frame:**
  - Stimulus: start, then words 0xA0..0xA3 on consecutive cycles, in_last on 0xA3.
  - Response: RAM[0..3]=0xA0..0xA3, done pulses once 1 cycle after the 0xA3 acceptance, err_len=0, address returns to 255.
- **Stalled frame:**
  - Stimulus: in_valid toggled 1,0,0,1,1,0,1.
  - Response: only valid words written, to addresses 0..3 in order; stall cycles show mem_address=255; RAM[4..254] untouched.
- **Length errors:**
  - in_last on word 1 → err_len=1, frame still completes after 4 words.
  - Next frame with in_last correct → err_len cleared by start, stays 0.
- **Ignored start:** start pulsed in the middle of a frame → wr_ptr unaffected, words land at 0..3, single done.
- **Reset mid-frame:** reset after 2 words → no done, state IDLE; a fresh start then writes new data at 0..3.
